// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types, limits and helpers for the
// single-port RAM arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam int MAX_NREQ   = 8;
    localparam int MIN_NREQ   = 2;
    localparam int MIN_RD_LAT = 1;
    localparam int MAX_RD_LAT = 4;
    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 8;
    localparam int CNT_W      = 2;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: master request/response lanes plus the shared
// RAM pins, bundled for the arbiter and its environment.
interface mem_arbiter_if #(
    parameter int NREQ = 2
) ();
    import mem_arb_pkg::*;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_we;
    logic [NREQ-1:0]        req_lock;
    logic [ADDR_W*NREQ-1:0] req_addr;
    logic [DATA_W*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_data;
    logic [ADDR_W-1:0]      ram_addr;
    logic [DATA_W-1:0]      ram_wdata;
    logic [DATA_W-1:0]      ram_rdata;
    logic                   ram_wr;
    logic                   ram_oe;

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_lock,
        input  req_addr,
        input  req_wdata,
        input  ram_rdata,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output ram_addr,
        output ram_wdata,
        output ram_wr,
        output ram_oe
    );

    modport master (
        output req_valid,
        output req_we,
        output req_lock,
        output req_addr,
        output req_wdata,
        output ram_rdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  ram_addr,
        input  ram_wdata,
        input  ram_wr,
        input  ram_oe
    );

endinterface

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selector; the search begins
// one past last_grant and wraps from N-1 back to 0.
module rr_picker #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = W'((int'(last_grant) + k) % N);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises byte accesses from NREQ masters onto one
// external RAM port with round-robin grants and optional burst lock.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int RD_LAT = 1
) (
    input  logic         clk_in,
    input  logic         reset_in,
    mem_arbiter_if.slave bus
);

    localparam int IW = idx_w(NREQ);

    if (NREQ < MIN_NREQ || NREQ > MAX_NREQ) begin : g_bad_nreq
        $error("mem_arbiter: NREQ out of range");
    end
    if (RD_LAT < MIN_RD_LAT || RD_LAT > MAX_RD_LAT) begin : g_bad_lat
        $error("mem_arbiter: RD_LAT out of range");
    end

    state_t state;
    state_t state_nx;

    logic [IW-1:0]     gnt_q;
    logic [IW-1:0]     last_grant;
    logic [IW-1:0]     lock_owner;
    logic              lock_valid;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  wait_cnt;

    logic              arb_en;
    logic              lock_hit;
    logic              pick_any;
    logic              accept;
    logic              capture;
    logic              busy;
    logic [NREQ-1:0]   pick_grant;
    logic [IW-1:0]     pick_idx;
    logic [IW-1:0]     win_idx;

    rr_picker #(
        .N (NREQ),
        .W (IW)
    ) u_pick (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .idx        (pick_idx),
        .any        (pick_any)
    );

    // Reset gates acceptance so nothing is latched on a reset edge.
    assign arb_en   = !reset_in &&
                      (state == IDLE || state == DONE);
    assign lock_hit = lock_valid && bus.req_valid[lock_owner];
    assign win_idx  = lock_hit ? lock_owner : pick_idx;
    assign accept   = arb_en && (lock_hit || pick_any);

    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            if (lock_hit) begin
                bus.req_ready[lock_owner] = 1'b1;
            end else begin
                bus.req_ready = pick_grant;
            end
        end
    end

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_nx = DONE;
                end else if (RD_LAT == 1) begin
                    capture  = 1'b1;
                    state_nx = DONE;
                end else begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    capture  = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = accept ? ISSUE : IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state      <= IDLE;
            gnt_q      <= '0;
            last_grant <= IW'(NREQ - 1);
            lock_owner <= '0;
            lock_valid <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            wait_cnt   <= '0;
        end else begin
            state <= state_nx;
            if (arb_en && !lock_hit) begin
                lock_valid <= 1'b0;
            end
            if (accept) begin
                gnt_q      <= win_idx;
                last_grant <= win_idx;
                lock_owner <= win_idx;
                lock_valid <= bus.req_lock[win_idx];
                we_q       <= bus.req_we[win_idx];
                addr_q     <= bus.req_addr[win_idx*ADDR_W +: ADDR_W];
                wdata_q    <= bus.req_wdata[win_idx*DATA_W +: DATA_W];
            end
            // Remaining WAIT cycles after ISSUE, minus one.
            if (state == ISSUE) begin
                wait_cnt <= CNT_W'(RD_LAT > 1 ? RD_LAT - 2 : 0);
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (capture) begin
                rdata_q <= bus.ram_rdata;
            end
        end
    end

    assign busy          = (state == ISSUE) || (state == WAIT);
    assign bus.ram_addr  = busy ? addr_q : '0;
    assign bus.ram_wdata = (state == ISSUE) ? wdata_q : '0;
    assign bus.ram_wr    = (state == ISSUE) && we_q;
    assign bus.ram_oe    = ((state == ISSUE) && !we_q) ||
                           (state == WAIT);
    assign bus.rsp_data  = rdata_q;

    always_comb begin
        bus.rsp_valid = '0;
        if (state == DONE) begin
            bus.rsp_valid[gnt_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter
// against a transaction-level model of grants, timing and data.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int N = 3;
    localparam int L = 2;

    typedef struct packed {
        logic        we;
        logic        lock;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } rq_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_arbiter_if #(.NREQ(N)) bus ();

    mem_arbiter #(
        .NREQ   (N),
        .RD_LAT (L)
    ) dut (
        .clk_in   (clk),
        .reset_in (rst),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // RAM device: data is only valid on the L-th cycle of ram_oe.
    logic [7:0] ram_dev [0:65535];
    logic [7:0] ram_ref [0:65535];
    int oe_run = 0;

    always @(posedge clk) begin
        if (bus.ram_wr) ram_dev[bus.ram_addr] <= bus.ram_wdata;
        oe_run <= bus.ram_oe ? oe_run + 1 : 0;
    end

    assign bus.ram_rdata = (bus.ram_oe && oe_run == L - 1) ?
                           ram_dev[bus.ram_addr] :
                           ~ram_dev[bus.ram_addr];

    rq_t        q [N][$];
    rq_t        cur [N];
    logic [N-1:0] cur_v = '0;
    logic       rst_nx = 1'b1;
    bit         rnd = 1'b0;

    int         m_last = N - 1;
    bit         m_lock_v = 1'b0;
    int         m_lock_own = 0;
    bit         tx_v = 1'b0;
    int         tx_age = 0;
    int         tx_port = 0;
    rq_t        tx;
    logic [7:0] tx_exp = '0;
    logic [7:0] m_rdata = '0;
    int         glog [$];

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h cycle=%0d",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic int dur(input logic we);
        return we ? 2 : L + 1;
    endfunction

    function automatic bit pending();
        bit p = (cur_v != '0);
        for (int i = 0; i < N; i++) if (q[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (cur_v[i] && rnd && $urandom_range(0, 31) == 0)
                cur_v[i] = 1'b0;
            if (!cur_v[i] && q[i].size() > 0 &&
                (!rnd || $urandom_range(0, 3) != 0)) begin
                cur[i]   = q[i].pop_front();
                cur_v[i] = 1'b1;
            end
            bus.req_valid[i]           = cur_v[i];
            bus.req_we[i]              = cur[i].we;
            bus.req_lock[i]            = cur[i].lock;
            bus.req_addr[16*i +: 16]   = cur[i].addr;
            bus.req_wdata[8*i +: 8]    = cur[i].wdata;
        end
        rst = rst_nx;
    endtask

    task automatic model_cycle();
        logic [N-1:0] e_ready = '0;
        logic [N-1:0] e_rsp = '0;
        logic         e_wr = 1'b0;
        logic         e_oe = 1'b0;
        logic [15:0]  e_addr = '0;
        bit           done_now;
        bit           free;
        int           win = -1;
        done_now = tx_v && tx_age == dur(tx.we);
        free     = !tx_v || done_now;
        if (tx_v) begin
            if (done_now) begin
                e_rsp[tx_port] = 1'b1;
                if (!tx.we) m_rdata = tx_exp;
            end else if (tx.we) begin
                e_wr   = 1'b1;
                e_addr = tx.addr;
            end else begin
                e_oe   = 1'b1;
                e_addr = tx.addr;
            end
        end
        if (free && !rst) begin
            if (m_lock_v && cur_v[m_lock_own]) begin
                win = m_lock_own;
            end else begin
                for (int k = 1; k <= N; k++)
                    if (win < 0 && cur_v[(m_last + k) % N])
                        win = (m_last + k) % N;
            end
        end
        if (win >= 0) e_ready[win] = 1'b1;
        chk("req_ready", bus.req_ready, e_ready);
        chk("rsp_valid", bus.rsp_valid, e_rsp);
        chk("ram_wr", bus.ram_wr, e_wr);
        chk("ram_oe", bus.ram_oe, e_oe);
        chk("ram_addr", bus.ram_addr, e_addr);
        if (e_wr) chk("ram_wdata", bus.ram_wdata, tx.wdata);
        chk("rsp_data", bus.rsp_data, m_rdata);
        if (rst) begin
            tx_v = 1'b0;
            m_last = N - 1;
            m_lock_v = 1'b0;
            m_lock_own = 0;
            m_rdata = '0;
            return;
        end
        if (done_now) tx_v = 1'b0;
        if (tx_v) tx_age++;
        if (free && !cur_v[m_lock_own]) m_lock_v = 1'b0;
        if (win >= 0) begin
            tx_v    = 1'b1;
            tx_age  = 1;
            tx_port = win;
            tx      = cur[win];
            if (tx.we) ram_ref[tx.addr] = tx.wdata;
            else tx_exp = ram_ref[tx.addr];
            m_last     = win;
            m_lock_v   = cur[win].lock;
            m_lock_own = win;
            cur_v[win] = 1'b0;
            glog.push_back(win);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        model_cycle();
        cyc++;
    endtask

    task automatic drain();
        int n = 0;
        while ((pending() || tx_v) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) chk("drain_timeout", 1, 0);
        step();
        step();
    endtask

    task automatic push(input int p, input logic we,
                        input logic lock, input logic [15:0] a,
                        input logic [7:0] d);
        rq_t r;
        r.we = we;
        r.lock = lock;
        r.addr = a;
        r.wdata = d;
        q[p].push_back(r);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    int lk_exp [4] = '{2, 2, 2, 0};
    int ct_exp [6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_lock  = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int a = 0; a < 65536; a++) begin
            logic [15:0] av;
            logic [7:0]  b;
            av = 16'(a);
            b  = av[7:0] ^ av[15:8] ^ 8'h5a;
            if (av == 16'h00ff) b = 8'h3c;
            ram_dev[a] <= b;
            ram_ref[a] = b;
        end

        // Reset held with every port requesting.
        for (int i = 0; i < N; i++) push(i, 1'b0, 1'b0, 16'(i + 1), 8'h00);
        rst_nx = 1'b1;
        step();
        step();
        rst_nx = 1'b0;
        glog.delete();
        drain();
        chk("first_grant", glog.size() > 0 ? glog[0] : -1, 0);

        // Single read from port 0.
        push(0, 1'b0, 1'b0, 16'h00ff, 8'h00);
        drain();
        chk("rd_data", bus.rsp_data, 8'h3c);

        // Single write from port 1.
        push(1, 1'b1, 1'b0, 16'h1234, 8'ha5);
        drain();

        // Locked burst from port 2 against port 0.
        glog.delete();
        push(0, 1'b1, 1'b0, 16'h0020, 8'h11);
        for (int i = 0; i < 3; i++)
            push(2, 1'b1, 1'b1, 16'(16'h0030 + i), 8'(8'h70 + i));
        drain();
        chk("lock_cnt", glog.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("lock_order", glog.size() > i ? glog[i] : -1, lk_exp[i]);

        push(0, 1'b0, 1'b0, 16'h1234, 8'h00);
        drain();
        chk("wr_readback", bus.rsp_data, 8'ha5);

        // Reset while the read sits in WAIT.
        push(0, 1'b0, 1'b0, 16'h0040, 8'h00);
        for (int n = 0; n < 20 && !(tx_v && tx_age == 2); n++) step();
        chk("reach_wait", tx_v && tx_age == 2, 1);
        rst_nx = 1'b1;
        step();
        rst_nx = 1'b0;
        step();
        chk("oe_after_rst", bus.ram_oe, 0);
        chk("rsp_after_rst", bus.rsp_valid, 0);

        // All ports contending continuously.
        glog.delete();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++)
                push(i, 1'b1, 1'b0, 16'(16'h0050 + 4*r + i), 8'(r*16 + i));
        drain();
        chk("cont_cnt", glog.size(), 6);
        for (int i = 0; i < 6; i++)
            chk("cont_order", glog.size() > i ? glog[i] : -1, ct_exp[i]);

        // Random traffic with locks, drops and occasional resets.
        rnd = 1'b1;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                int p;
                p = $urandom_range(0, N - 1);
                if (q[p].size() < 3)
                    push(p, 1'($urandom_range(0, 1)),
                         $urandom_range(0, 3) == 0,
                         16'($urandom_range(0, 15)),
                         8'($urandom_range(0, 255)));
            end
            rst_nx = ($urandom_range(0, 249) == 0);
            step();
        end
        rst_nx = 1'b0;
        rnd = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
